uart_core: RTL and testbench
============================

UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter DBITS, default 8, data bits per frame.
REQ-002 Parameter SB_TICK, default 16, sample ticks in the stop bit (16 = 1 stop bit).
REQ-003 Parameter BR_BITS, default 6, baud counter width.
REQ-004 Parameter BR_LIMIT, default 53, clocks per sample tick (16x oversampling; 53 at 100 MHz gives about 115200 baud).
REQ-005 Port: clk  input  1  system clock; all logic is on its rising edge.
REQ-006 Port: reset  input  1  one clock; reset is asynchronous and active-low.
REQ-007 Port: rx  input  1  serial receive line, idle high, asynchronous to clk.
REQ-008 Port: rx_data_out  output  DBITS  last received byte.
REQ-009 Port: rx_done  output  1  one-cycle pulse when rx_data_out is updated.
REQ-010 Port: tx_start  input  1  level request to send a frame.
REQ-011 Port: tx_data_in  input  DBITS  byte to transmit.
REQ-012 Port: tx_done  output  1  one-cycle pulse at the end of the stop bit.
REQ-013 Port: tx  output  1  serial transmit line, idle high.

Function
REQ-014 Tick generator: a BR_BITS counter counts 0..BR_LIMIT-1 and wraps; tick is high for exactly one clk when the count equals BR_LIMIT-1.
REQ-015 Frame format: 1 start bit (0), DBITS data bits LSB first, stop of SB_TICK ticks (1), no parity; each start/data bit lasts 16 ticks.
REQ-016 rx passes through a 2-FF synchronizer before any use.
REQ-017 Receiver states are IDLE, START, DATA and STOP.
REQ-018 IDLE to START on the synchronized rx equal to 0.
REQ-019 START: at the 8th tick (mid-bit), if rx is 0 the receiver goes to DATA; otherwise it returns to IDLE (glitch reject).
REQ-020 DATA: sample at every 16th tick and shift right into the MSB; go to STOP after DBITS samples.
REQ-021 STOP: after SB_TICK ticks, load rx_data_out, pulse rx_done for one clk, and return to IDLE.
REQ-022 rx_data_out holds its value until the next completed frame.
REQ-023 Transmitter states are IDLE, START, DATA and STOP.
REQ-024 In IDLE, tx_start high (sampled each clk) enters START and drives tx to 0, aligned to the next tick.
REQ-025 tx_data_in is latched on the last tick of the start bit, so data may change up to that point.
REQ-026 DATA shifts out LSB first, 16 ticks per bit.
REQ-027 STOP drives tx to 1 for SB_TICK ticks, then pulses tx_done for one clk and returns to IDLE.
REQ-028 If tx_start is still high in IDLE, the next frame starts back-to-back.
REQ-029 tx_start is ignored while a frame is in progress.
REQ-030 tx is a registered output and is glitch-free.
REQ-031 The receiver and transmitter are fully independent; simultaneous RX and TX operation is required.

Reset
REQ-032 While reset is low, asynchronously: tick counter = 0, both FSMs = IDLE, tx = 1, tx_done = 0, rx_done = 0, rx_data_out = 0, shift registers = 0, synchronizer flops = 1.
REQ-033 Reset mid-frame aborts the frame with no done pulse; after release the receiver waits for a new falling edge.

Configuration
REQ-034 Macro UART_FRAME_ERR_EN: when defined, output rx_frame_err (1 bit) is added.
REQ-035 With UART_FRAME_ERR_EN defined, rx_frame_err is set with rx_done if rx was 0 at the mid-stop sample, and is cleared with the next rx_done or reset; rx_data_out is still updated.
REQ-036 With UART_FRAME_ERR_EN undefined, the port and its logic are absent, and the stop-bit value is ignored.

Structure
REQ-037 Package uart_pkg holds default DBITS, SB_TICK, BR_BITS and BR_LIMIT, plus the shared rx/tx FSM state typedef.
REQ-038 The tick generator is one sub-module, uart_baud_tick; the RX and TX FSMs are written inline in uart_core.

Verification
REQ-039 Tick: after reset release, tick pulses every 53 clks, first at clk 53, and never two in a row.
REQ-040 TX: pulse tx_start with tx_data_in = 0x41 -> tx = 0,1,0,0,0,0,0,1,0,1, each bit 848 clks; tx_done one clk after the stop bit; tx stays at 1.
REQ-041 RX: drive a 0x0D frame at 848 clks/bit -> exactly one rx_done pulse with rx_data_out = 0x0D, then the next frame 0x0A -> 0x0A.
REQ-042 Glitch: rx low for 3 ticks then high -> no rx_done, and the receiver is back in IDLE.
REQ-043 Back-to-back: hold tx_start high, changing tx_data_in 0x31 -> 0x32 within 2 clks after tx_done -> two contiguous frames carrying 0x31 then 0x32.
REQ-044 Reset and error: assert reset mid-TX of 0x55 -> tx = 1 immediately and no tx_done; with UART_FRAME_ERR_EN, an RX frame with stop = 0 -> rx_frame_err = 1 together with rx_done.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared defaults and FSM state encoding for the UART core.
package uart_pkg;

  localparam int DBITS_DEF    = 8;
  localparam int SB_TICK_DEF  = 16;
  localparam int BR_BITS_DEF  = 6;
  localparam int BR_LIMIT_DEF = 53;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator: one-clock pulse every BR_LIMIT clocks.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int BR_BITS  = BR_BITS_DEF,
  parameter int BR_LIMIT = BR_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [BR_BITS-1:0] CNT_LAST = BR_BITS'(BR_LIMIT - 1);

  logic [BR_BITS-1:0] cnt_r;
  logic [BR_BITS-1:0] cnt_next_s;
  logic               tick_r;

  // Wrapping count
  always_comb begin
    cnt_next_s = cnt_r;
    if (cnt_r == CNT_LAST) begin
      cnt_next_s = '0;
    end else begin
      cnt_next_s = cnt_r + BR_BITS'(1);
    end
  end

  // Tick is registered so it is high exactly while the count sits at its last value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_next_s;
      tick_r <= (cnt_next_s == CNT_LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_core.sv
// UART receiver and transmitter sharing one baud tick, no parity.
// Optional rx_frame_err output enabled by defining UART_FRAME_ERR_EN.
module uart_core
  import uart_pkg::*;
#(
  parameter int DBITS    = DBITS_DEF,
  parameter int SB_TICK  = SB_TICK_DEF,
  parameter int BR_BITS  = BR_BITS_DEF,
  parameter int BR_LIMIT = BR_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic [DBITS-1:0] rx_data_out,
  output logic             rx_done,
  input  logic             tx_start,
  input  logic [DBITS-1:0] tx_data_in,
  output logic             tx_done,
`ifdef UART_FRAME_ERR_EN
  output logic             rx_frame_err,
`endif
  output logic             tx
);

  localparam int SCW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NCW = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam logic [SCW-1:0] S_MID  = SCW'(7);
  localparam logic [SCW-1:0] S_LAST = SCW'(15);
  localparam logic [SCW-1:0] S_STOP = SCW'(SB_TICK - 1);
  localparam logic [NCW-1:0] N_LAST = NCW'(DBITS - 1);

  logic tick_s;
  logic rx_meta_r, rx_sync_r;

  uart_state_e      rx_state_r, rx_state_next_s;
  logic [SCW-1:0]   rx_s_r, rx_s_next_s;
  logic [NCW-1:0]   rx_n_r, rx_n_next_s;
  logic [DBITS-1:0] rx_b_r, rx_b_next_s;
  logic [DBITS-1:0] rx_data_r;
  logic             rx_done_s, rx_done_r;

  uart_state_e      tx_state_r, tx_state_next_s;
  logic [SCW-1:0]   tx_s_r, tx_s_next_s;
  logic [NCW-1:0]   tx_n_r, tx_n_next_s;
  logic [DBITS-1:0] tx_b_r, tx_b_next_s;
  logic             tx_req_r, tx_req_next_s;
  logic             tx_done_s, tx_done_r;
  logic             tx_bit_s, tx_r;

  uart_baud_tick #(
    .BR_BITS (BR_BITS),
    .BR_LIMIT(BR_LIMIT)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick_s)
  );

  // Two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receiver state registers and output holding registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_r <= ST_IDLE;
      rx_s_r     <= '0;
      rx_n_r     <= '0;
      rx_b_r     <= '0;
      rx_done_r  <= 1'b0;
      rx_data_r  <= '0;
    end else begin
      rx_state_r <= rx_state_next_s;
      rx_s_r     <= rx_s_next_s;
      rx_n_r     <= rx_n_next_s;
      rx_b_r     <= rx_b_next_s;
      rx_done_r  <= rx_done_s;
      rx_data_r  <= rx_done_s ? rx_b_r : rx_data_r;
    end
  end

  // Receiver next state: mid-bit sampling, START re-checks the line to reject glitches
  always_comb begin
    rx_state_next_s = rx_state_r;
    rx_s_next_s     = rx_s_r;
    rx_n_next_s     = rx_n_r;
    rx_b_next_s     = rx_b_r;
    rx_done_s       = 1'b0;
    case (rx_state_r)
      ST_IDLE: begin
        if (!rx_sync_r) begin
          rx_state_next_s = ST_START;
          rx_s_next_s     = '0;
        end else begin
          rx_state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s && (rx_s_r == S_MID)) begin
          if (!rx_sync_r) begin
            rx_state_next_s = ST_DATA;
            rx_s_next_s     = '0;
            rx_n_next_s     = '0;
          end else begin
            rx_state_next_s = ST_IDLE;
          end
        end else if (tick_s) begin
          rx_s_next_s = rx_s_r + SCW'(1);
        end else begin
          rx_s_next_s = rx_s_r;
        end
      end
      ST_DATA: begin
        if (tick_s && (rx_s_r == S_LAST)) begin
          rx_s_next_s = '0;
          rx_b_next_s = {rx_sync_r, rx_b_r[DBITS-1:1]};
          if (rx_n_r == N_LAST) begin
            rx_state_next_s = ST_STOP;
          end else begin
            rx_n_next_s = rx_n_r + NCW'(1);
          end
        end else if (tick_s) begin
          rx_s_next_s = rx_s_r + SCW'(1);
        end else begin
          rx_s_next_s = rx_s_r;
        end
      end
      ST_STOP: begin
        if (tick_s && (rx_s_r == S_STOP)) begin
          rx_state_next_s = ST_IDLE;
          rx_done_s       = 1'b1;
        end else if (tick_s) begin
          rx_s_next_s = rx_s_r + SCW'(1);
        end else begin
          rx_s_next_s = rx_s_r;
        end
      end
      default: rx_state_next_s = ST_IDLE;
    endcase
  end

`ifdef UART_FRAME_ERR_EN
  logic rx_frame_err_r;

  // Stop-bit level at the final stop sample, captured with each completed frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_frame_err_r <= 1'b0;
    end else if (rx_done_s) begin
      rx_frame_err_r <= ~rx_sync_r;
    end else begin
      rx_frame_err_r <= rx_frame_err_r;
    end
  end

  assign rx_frame_err = rx_frame_err_r;
`endif

  // Transmitter state registers; tx itself is a flop for a glitch-free line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_r <= ST_IDLE;
      tx_s_r     <= '0;
      tx_n_r     <= '0;
      tx_b_r     <= '0;
      tx_req_r   <= 1'b0;
      tx_done_r  <= 1'b0;
      tx_r       <= 1'b1;
    end else begin
      tx_state_r <= tx_state_next_s;
      tx_s_r     <= tx_s_next_s;
      tx_n_r     <= tx_n_next_s;
      tx_b_r     <= tx_b_next_s;
      tx_req_r   <= tx_req_next_s;
      tx_done_r  <= tx_done_s;
      tx_r       <= tx_bit_s;
    end
  end

  // Transmitter next state; a request seen between ticks is held until the next tick
  always_comb begin
    tx_state_next_s = tx_state_r;
    tx_s_next_s     = tx_s_r;
    tx_n_next_s     = tx_n_r;
    tx_b_next_s     = tx_b_r;
    tx_req_next_s   = tx_req_r;
    tx_done_s       = 1'b0;
    tx_bit_s        = 1'b1;
    case (tx_state_r)
      ST_IDLE: begin
        if (tick_s && (tx_start || tx_req_r)) begin
          tx_state_next_s = ST_START;
          tx_s_next_s     = '0;
          tx_req_next_s   = 1'b0;
        end else if (tx_start) begin
          tx_req_next_s = 1'b1;
        end else begin
          tx_req_next_s = tx_req_r;
        end
      end
      ST_START: begin
        if (tick_s && (tx_s_r == S_LAST)) begin
          tx_state_next_s = ST_DATA;
          tx_s_next_s     = '0;
          tx_n_next_s     = '0;
          tx_b_next_s     = tx_data_in;
        end else if (tick_s) begin
          tx_s_next_s = tx_s_r + SCW'(1);
        end else begin
          tx_s_next_s = tx_s_r;
        end
      end
      ST_DATA: begin
        if (tick_s && (tx_s_r == S_LAST)) begin
          tx_s_next_s = '0;
          tx_b_next_s = {1'b0, tx_b_r[DBITS-1:1]};
          if (tx_n_r == N_LAST) begin
            tx_state_next_s = ST_STOP;
          end else begin
            tx_n_next_s = tx_n_r + NCW'(1);
          end
        end else if (tick_s) begin
          tx_s_next_s = tx_s_r + SCW'(1);
        end else begin
          tx_s_next_s = tx_s_r;
        end
      end
      ST_STOP: begin
        // A held request restarts on this same tick so frames stay contiguous
        if (tick_s && (tx_s_r == S_STOP)) begin
          tx_done_s       = 1'b1;
          tx_s_next_s     = '0;
          tx_state_next_s = tx_start ? ST_START : ST_IDLE;
        end else if (tick_s) begin
          tx_s_next_s = tx_s_r + SCW'(1);
        end else begin
          tx_s_next_s = tx_s_r;
        end
      end
      default: tx_state_next_s = ST_IDLE;
    endcase
    case (tx_state_next_s)
      ST_START: tx_bit_s = 1'b0;
      ST_DATA:  tx_bit_s = tx_b_next_s[0];
      default:  tx_bit_s = 1'b1;
    endcase
  end

  assign rx_data_out = rx_data_r;
  assign rx_done     = rx_done_r;
  assign tx_done     = tx_done_r;
  assign tx          = tx_r;

endmodule

// File: tb/tb_uart_core.sv
// Table-driven bench for uart_core plus directed multi-cycle sequences.
module tb_uart_core;
  import uart_pkg::*;

  localparam int BIT_CLKS   = 848;
  localparam int FRAME_CLKS = 8480;

  typedef struct {
    bit         is_tx;
    logic [7:0] stim;
    logic [9:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data_in = 8'h00;
  logic [7:0] rx_data_out;
  logic       rx_done;
  logic       tx_done;
  logic       tx;
`ifdef UART_FRAME_ERR_EN
  logic       rx_frame_err;
  logic       err_cap = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int rx_done_cnt = 0;
  int tx_done_cnt = 0;
  logic [7:0] rx_cap = 8'h00;

  uart_core dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data_out(rx_data_out),
    .rx_done    (rx_done),
    .tx_start   (tx_start),
    .tx_data_in (tx_data_in),
    .tx_done    (tx_done),
`ifdef UART_FRAME_ERR_EN
    .rx_frame_err(rx_frame_err),
`endif
    .tx         (tx)
  );

  always #5 clk = ~clk;

  // Count done pulses and capture data seen with each rx_done
  always @(negedge clk) begin
    if (rx_done) begin
      rx_done_cnt <= rx_done_cnt + 1;
      rx_cap      <= rx_data_out;
`ifdef UART_FRAME_ERR_EN
      err_cap     <= rx_frame_err;
`endif
    end
    if (tx_done) tx_done_cnt <= tx_done_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_tx(input logic [7:0] d);
    tx_data_in = d;
    tx_start   = 1'b1;
    @(negedge clk);
    tx_start   = 1'b0;
  endtask

  // Follows nf frames from the first falling edge, checking both ends of every bit
  task automatic tx_check(input string name, input logic [9:0] f0, input logic [9:0] f1,
                          input int nf, input logic [7:0] d1);
    int waited;
    int base;
    int f;
    int r;
    int b;
    logic [9:0] fr;
    waited = 0;
    while (tx !== 1'b0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL %s start: tx=%b expected 0 within 200 clks", name, tx);
      return;
    end
    base = tx_done_cnt;
    for (int j = 0; j <= nf * FRAME_CLKS + 20; j++) begin
      f = j / FRAME_CLKS;
      r = j % BIT_CLKS;
      b = (j % FRAME_CLKS) / BIT_CLKS;
      if (nf > 1 && j == FRAME_CLKS) tx_data_in = d1;
      if (nf > 1 && j == FRAME_CLKS + 100) tx_start = 1'b0;
      if (f < nf && (r == 0 || r == BIT_CLKS - 1)) begin
        fr = (f == 0) ? f0 : f1;
        check($sformatf("%s f%0d bit%0d j%0d", name, f, b, j), 32'(tx), 32'(fr[b]));
      end
      if (f >= nf) check($sformatf("%s idle j%0d", name, j), 32'(tx), 32'd1);
      if (tx_done) check($sformatf("%s done_pos", name), 32'(j % FRAME_CLKS), 32'd0);
      @(negedge clk);
    end
    check($sformatf("%s done_count", name), 32'(tx_done_cnt - base), 32'(nf));
  endtask

  task automatic rx_send(input logic [7:0] d, input logic stop_bit, input int tail);
    logic [9:0] fr;
    fr = {stop_bit, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx = fr[b];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = 1'b1;
    repeat (tail) @(negedge clk);
  endtask

  task automatic rx_check(input string name, input logic [7:0] d, input int base);
    check($sformatf("%s done_count", name), 32'(rx_done_cnt - base), 32'd1);
    check($sformatf("%s captured", name), 32'(rx_cap), 32'(d));
    check($sformatf("%s data_out", name), 32'(rx_data_out), 32'(d));
  endtask

  initial begin
    vec_t vecs[4];
    int base;
    int tbase;
    vecs[0] = '{is_tx: 1'b1, stim: 8'h41, exp: 10'h282};
    vecs[1] = '{is_tx: 1'b0, stim: 8'h0D, exp: 10'h00D};
    vecs[2] = '{is_tx: 1'b0, stim: 8'h0A, exp: 10'h00A};
    vecs[3] = '{is_tx: 1'b1, stim: 8'hA5, exp: 10'h34A};

    repeat (3) @(negedge clk);
    check("reset tx", 32'(tx), 32'd1);
    check("reset tx_done", 32'(tx_done), 32'd0);
    check("reset rx_done", 32'(rx_done), 32'd0);
    check("reset rx_data_out", 32'(rx_data_out), 32'd0);
    reset = 1'b1;

    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      check($sformatf("tick k%0d", k), 32'(dut.tick_s), 32'((k % 53) == 52));
    end

    foreach (vecs[i]) begin
      if (vecs[i].is_tx) begin
        pulse_tx(vecs[i].stim);
        tx_check($sformatf("vec%0d tx", i), vecs[i].exp, vecs[i].exp, 1, vecs[i].stim);
      end else begin
        base = rx_done_cnt;
        rx_send(vecs[i].stim, 1'b1, 200);
        rx_check($sformatf("vec%0d rx", i), vecs[i].exp[7:0], base);
      end
    end

    // Short low pulse must be rejected at the mid-start sample
    base = rx_done_cnt;
    rx = 1'b0;
    repeat (159) @(negedge clk);
    rx = 1'b1;
    repeat (1000) @(negedge clk);
    check("glitch no done", 32'(rx_done_cnt - base), 32'd0);
    check("glitch idle", 32'(dut.rx_state_r), 32'(ST_IDLE));
    check("glitch data held", 32'(rx_data_out), 32'h0A);

    // Back-to-back frames with data swapped just after the first tx_done
    tx_data_in = 8'h31;
    tx_start   = 1'b1;
    tx_check("b2b", 10'h262, 10'h264, 2, 8'h32);

`ifdef UART_FRAME_ERR_EN
    base = rx_done_cnt;
    rx_send(8'h96, 1'b0, 1000);
    rx_check("ferr rx", 8'h96, base);
    check("ferr flag", 32'(err_cap), 32'd1);
`endif

    // Simultaneous receive and transmit
    base = rx_done_cnt;
    fork
      rx_send(8'hC3, 1'b1, 200);
      begin
        pulse_tx(8'h3C);
        tx_check("sim tx", 10'h278, 10'h278, 1, 8'h3C);
      end
    join
    rx_check("sim rx", 8'hC3, base);
`ifdef UART_FRAME_ERR_EN
    check("ferr cleared cap", 32'(err_cap), 32'd0);
    check("ferr cleared out", 32'(rx_frame_err), 32'd0);
`endif

    // Reset in the middle of a transmit frame
    pulse_tx(8'h55);
    repeat (2000) @(negedge clk);
    tbase = tx_done_cnt;
    reset = 1'b0;
    #1;
    check("midreset tx", 32'(tx), 32'd1);
    check("midreset tx_done", 32'(tx_done), 32'd0);
    check("midreset rx_data_out", 32'(rx_data_out), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (7000) @(negedge clk);
    check("midreset no done", 32'(tx_done_cnt - tbase), 32'd0);
    check("midreset tx idle", 32'(tx), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
